// File: rtl/jellyvl_synctimer_adjuster_if.sv
`default_nettype none
// ============================================================================
// Module      : jellyvl_synctimer_adjuster_if
// Description : Timer-side control bundle of the sync-timer adjuster:
//               hard-load strobe plus the +/-1 adjust request handshake.
// Revision    : 1.0  initial release
// ============================================================================
interface jellyvl_synctimer_adjuster_if #(
  parameter int TIMER_WIDTH = 64
);
  logic [TIMER_WIDTH-1:0] set_time;
  logic                   set_valid;
  logic                   adjust_sign;
  logic                   adjust_valid;
  logic                   adjust_ready;

  // Adjuster side drives the timer.
  modport master (
    output set_time,
    output set_valid,
    output adjust_sign,
    output adjust_valid,
    input  adjust_ready
  );

  // Timer side consumes the requests.
  modport slave (
    input  set_time,
    input  set_valid,
    input  adjust_sign,
    input  adjust_valid,
    output adjust_ready
  );
endinterface
`default_nettype wire

// File: rtl/jellyvl_synctimer_adjuster.sv
`default_nettype none
// ============================================================================
// Module      : jellyvl_synctimer_adjuster
// Description : Compares master time against the local timer. Large errors
//               (or the first sync) hard-load the timer; small errors are
//               slewed as a rate-limited train of +/-1 adjust requests.
// Revision    : 1.0  initial release
// ============================================================================
module jellyvl_synctimer_adjuster #(
  parameter int                     TIMER_WIDTH    = 64,
  parameter int                     ERROR_WIDTH    = 32,
  parameter int                     INTERVAL_WIDTH = 16,
  parameter logic [TIMER_WIDTH-1:0] SET_OFFSET     = '0
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic [ERROR_WIDTH-1:0]    param_limit,
  input  wire logic [INTERVAL_WIDTH-1:0] param_interval,
  input  wire logic [TIMER_WIDTH-1:0]    current_time,
  input  wire logic [TIMER_WIDTH-1:0]    correct_time,
  input  wire logic                      correct_valid,
  jellyvl_synctimer_adjuster_if.master   tmr,
  output logic                           synced,
  output logic [ERROR_WIDTH-1:0]         pending_count,
  output logic [TIMER_WIDTH-1:0]         monitor_error,
  output logic                           monitor_valid
);

  localparam logic [TIMER_WIDTH-1:0]    C_TIME_ONE     = TIMER_WIDTH'(1);
  localparam logic [ERROR_WIDTH-1:0]    C_PENDING_ONE  = ERROR_WIDTH'(1);
  localparam logic [INTERVAL_WIDTH-1:0] C_INTERVAL_ONE = INTERVAL_WIDTH'(1);

  logic [TIMER_WIDTH-1:0]    set_time_q,      set_time_d;
  logic                      set_valid_q,     set_valid_d;
  logic                      adjust_sign_q,   adjust_sign_d;
  logic                      adjust_valid_q,  adjust_valid_d;
  logic                      synced_q,        synced_d;
  logic [ERROR_WIDTH-1:0]    pending_q,       pending_d;
  logic [INTERVAL_WIDTH-1:0] interval_q,      interval_d;
  logic [TIMER_WIDTH-1:0]    monitor_error_q, monitor_error_d;
  logic                      monitor_valid_q, monitor_valid_d;

  logic [TIMER_WIDTH-1:0]    error;
  logic                      error_neg;
  logic [TIMER_WIDTH:0]      error_abs;
  logic                      mag_ovf;
  logic [ERROR_WIDTH-1:0]    mag;
  logic                      hard_load;
  logic [INTERVAL_WIDTH-1:0] interval_max;
  logic                      handshake;

  // Error measurement, load/slew decision and request spacing.
  always_comb begin
    // Wrap-around falls out of modular subtraction; the extra magnitude bit
    // keeps the most negative error exact.
    error     = correct_time - current_time;
    error_neg = error[TIMER_WIDTH-1];
    error_abs = error_neg ? {1'b0, (~error) + C_TIME_ONE} : {1'b0, error};
    mag_ovf   = (error_abs >> ERROR_WIDTH) != '0;
    mag       = error_abs[ERROR_WIDTH-1:0];
    hard_load = !synced_q || mag_ovf || (mag > param_limit);

    // An interval of 0 behaves like 1.
    interval_max = (param_interval == '0) ? '0 : (param_interval - C_INTERVAL_ONE);
    handshake    = adjust_valid_q & tmr.adjust_ready;

    set_time_d      = set_time_q;
    set_valid_d     = 1'b0;
    adjust_sign_d   = adjust_sign_q;
    adjust_valid_d  = adjust_valid_q;
    synced_d        = synced_q;
    pending_d       = pending_q;
    interval_d      = interval_q;
    monitor_error_d = monitor_error_q;
    monitor_valid_d = 1'b0;

    if (correct_valid) begin
      // A fresh measurement supersedes everything, including a handshake
      // completing in this same cycle.
      monitor_error_d = error;
      monitor_valid_d = 1'b1;
      adjust_valid_d  = 1'b0;
      interval_d      = '0;
      if (hard_load) begin
        set_time_d  = correct_time + SET_OFFSET;
        set_valid_d = 1'b1;
        pending_d   = '0;
        synced_d    = 1'b1;
      end else begin
        pending_d     = mag;
        adjust_sign_d = error_neg;
      end
    end else if (adjust_valid_q) begin
      // Hold the request until accepted; drop it afterwards so the spacing
      // counter restarts before the next step.
      if (handshake) begin
        pending_d      = pending_q - C_PENDING_ONE;
        interval_d     = '0;
        adjust_valid_d = 1'b0;
      end
    end else if (pending_q != '0) begin
      if (interval_q == interval_max) begin
        adjust_valid_d = 1'b1;
      end else begin
        interval_d = interval_q + C_INTERVAL_ONE;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_time_q      <= '0;
      set_valid_q     <= 1'b0;
      adjust_sign_q   <= 1'b0;
      adjust_valid_q  <= 1'b0;
      synced_q        <= 1'b0;
      pending_q       <= '0;
      interval_q      <= '0;
      monitor_error_q <= '0;
      monitor_valid_q <= 1'b0;
    end else begin
      set_time_q      <= set_time_d;
      set_valid_q     <= set_valid_d;
      adjust_sign_q   <= adjust_sign_d;
      adjust_valid_q  <= adjust_valid_d;
      synced_q        <= synced_d;
      pending_q       <= pending_d;
      interval_q      <= interval_d;
      monitor_error_q <= monitor_error_d;
      monitor_valid_q <= monitor_valid_d;
    end
  end

  assign tmr.set_time     = set_time_q;
  assign tmr.set_valid    = set_valid_q;
  assign tmr.adjust_sign  = adjust_sign_q;
  assign tmr.adjust_valid = adjust_valid_q;
  assign synced           = synced_q;
  assign pending_count    = pending_q;
  assign monitor_error    = monitor_error_q;
  assign monitor_valid    = monitor_valid_q;

endmodule
`default_nettype wire

// File: doc/jellyvl_synctimer_adjuster.md
Name: jellyvl_synctimer_adjuster

Overview:
Upstream control stage for the sync timer. It compares a master timestamp `correct_time` against the local `current_time` and decides how to close the gap. Large errors, or the first sync after reset, produce a hard load on `set_time`/`set_valid`. Small errors are slewed as a rate-limited train of ±1 adjust requests on the `adjust_sign`/`adjust_valid`/`adjust_ready` handshake that the timer consumes.

Parameters:
TIMER_WIDTH, 64, width of timestamps (matches timer).
ERROR_WIDTH, 32, width of the unsigned slew magnitude, limit and pending counter.
INTERVAL_WIDTH, 16, width of the inter-request spacing counter.
SET_OFFSET, 0, unsigned constant added to `correct_time` on a hard load (latency compensation), modulo 2^TIMER_WIDTH.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
param_limit  input  ERROR_WIDTH  max |error| handled by slewing; quasi-static
param_interval  input  INTERVAL_WIDTH  min cycles between adjust requests; 0 treated as 1; quasi-static
current_time  input  TIMER_WIDTH  local timer value
correct_time  input  TIMER_WIDTH  master time valid at the current cycle
correct_valid  input  1  one-cycle strobe, correct_time valid
set_time  output  TIMER_WIDTH  hard-load value to timer
set_valid  output  1  one-cycle hard-load strobe
adjust_sign  output  1  0 = speed up (local behind), 1 = slow down
adjust_valid  output  1  adjust request
adjust_ready  input  1  timer accepts; may depend combinationally on adjust_valid/adjust_sign
synced  output  1  at least one hard load done since reset
pending_count  output  ERROR_WIDTH  adjust steps still owed
monitor_error  output  TIMER_WIDTH  last measured signed error
monitor_valid  output  1  one-cycle strobe with monitor_error

Behaviour:
- Reset (reset=0, async): all outputs 0; interval counter 0; pending 0; synced 0.
- Error: on correct_valid, e = correct_time − current_time (both sampled the same cycle), mod 2^TIMER_WIDTH, read as signed two's complement. Wrap-around is therefore handled naturally.
- Magnitude: |e| computed in TIMER_WIDTH+1 bits, so −2^(TIMER_WIDTH−1) is exact. mag_ovf = |e| ≥ 2^ERROR_WIDTH.
- Decision at a correct_valid in cycle N; all effects are registered and appear at N+1:
  - Hard load when synced=0, or mag_ovf, or |e| > param_limit:
    - set_time = correct_time + SET_OFFSET; set_valid=1 for exactly one cycle.
    - pending=0; adjust_valid=0; interval counter=0; synced=1.
  - Slew otherwise:
    - pending = |e|; adjust_sign = e<0.
    - adjust_valid forced 0 at N+1; interval counter restarted at 0.
    - The new measurement fully supersedes any previous pending work.
  - Either case: monitor_error=e, monitor_valid=1 for one cycle.
  - e=0: slew path with pending=0, so no requests are issued.
- Request spacing:
  - The interval counter increments each cycle while adjust_valid=0 and pending>0, saturating at param_interval−1.
  - When counter = max(param_interval,1)−1 and pending>0, adjust_valid is asserted on the next cycle.
  - adjust_valid stays high, with adjust_sign stable, until a cycle with adjust_valid & adjust_ready.
  - On the handshake: pending −1 and counter = 0. adjust_valid drops on the next cycle if pending becomes 0, or falls to 0 to restart spacing otherwise.
  - Result: handshake-to-next-valid spacing is ≥ param_interval cycles.
- Only a new correct_valid or reset may drop adjust_valid without a handshake.
- Simultaneous correct_valid and handshake in the same cycle: the handshake completes (counted by the timer), but the pending decrement is discarded. The new measurement values win.
- No state machine beyond these two modes: IDLE (pending=0) and SLEW (pending>0). HARD is a single-cycle action, not a resident state.
- pending_count reflects the registered pending value.

Test Plan:
1. First sync: after reset, current_time=40, correct_time=1000, SET_OFFSET=2 → next cycle set_valid=1 for 1 cycle, set_time=1002, synced=1, adjust_valid never asserts, monitor_error=960.
2. Small positive error: synced, param_limit=100, param_interval=4, current_time=5000, correct_time=5003, adjust_ready=1 → exactly 3 handshakes with adjust_sign=0, ≥4 cycles apart; pending_count goes 3,2,1,0; no set_valid.
3. Ready back-pressure: e=−2 with adjust_ready held 0 for 5 cycles after valid → adjust_valid stays 1 with adjust_sign=1 and pending_count=2 throughout; then 2 handshakes.
4. Hard load on large error: synced, pending=7, e=−200, param_limit=100 → set_valid pulse, pending_count=0, adjust_valid=0 next cycle.
5. Supersede: pending=10 after 2 handshakes, then new e=−2 arriving in a handshake cycle → next cycle adjust_valid=0, pending_count=2, adjust_sign=1, then 2 slow-down handshakes.
6. Wrap and reset: current_time=2^64−2, correct_time=1 → e=+3 and slew, not hard load. Assert reset mid-train → all outputs 0 immediately; next correct_valid hard-loads.
